// File: rtl/divider_asm_0.sv
// divider_asm_0: sequential restoring (shift-subtract) unsigned divider.
// Computes quotient and remainder of dividend/divisor in L_word step edges
// after the load edge. A zero divisor completes in one edge with Error set.
// The block uses a Start/Ready handshake.
//
// Optional feature macro: DIVIDER_EARLY_EXIT_EN
//   When defined, a load with dividend < divisor (divisor != 0) completes in
//   one edge with quotient=0 and remainder=dividend.
//
// Ports:
//   clock     in   system clock, rising-edge active
//   reset     in   synchronous active-high reset
//   dividend  in   [L_word] unsigned dividend, sampled on the load edge
//   divisor   in   [L_word] unsigned divisor, sampled on the load edge
//   Start     in   begin a division; honoured only while Ready=1
//   quotient  out  [L_word] registered quotient, valid in S_done
//   remainder out  [L_word] registered remainder, valid in S_done
//   Ready     out  combinational; idle (outside reset) or done
//   Error     out  registered divide-by-zero flag
module divider_asm_0 #(
   parameter int unsigned L_word = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [L_word-1:0] dividend,
   input  logic [L_word-1:0] divisor,
   input  logic              Start,
   output logic [L_word-1:0] quotient,
   output logic [L_word-1:0] remainder,
   output logic              Ready,
   output logic              Error
);

   localparam int unsigned CNT_W = $clog2(L_word + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DIVIDING = 2'd1,
      S_DONE     = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_n;
   logic                w_load;
   logic                w_step;
   logic                w_div_zero;
   logic                w_early;

   // The partial remainder always stays below the divisor, so L_word bits
   // hold it; the extra bit of the trial subtraction is only the sign.
   logic [L_word-1:0]   r_rem;
   logic [L_word-1:0]   r_shift;
   logic [L_word-1:0]   r_dsr;
   logic [CNT_W-1:0]    r_count;

   logic [L_word:0]     w_partial;
   logic [L_word:0]     w_trial;
   logic                w_neg;
   logic [L_word-1:0]   w_rem_n;
   logic [L_word-1:0]   w_shift_n;

   assign w_div_zero = (divisor == '0);

`ifdef DIVIDER_EARLY_EXIT_EN
   assign w_early = !w_div_zero && (dividend < divisor);
`else
   assign w_early = 1'b0;
`endif

   // One restoring step: shift in next dividend bit, trial-subtract divisor.
   assign w_partial = {r_rem, r_shift[L_word-1]};
   assign w_trial   = w_partial - {1'b0, r_dsr};
   assign w_neg     = w_trial[L_word];
   assign w_rem_n   = w_neg ? w_partial[L_word-1:0] : w_trial[L_word-1:0];
   assign w_shift_n = {r_shift[L_word-2:0], ~w_neg};

   assign Ready = ((r_state == S_IDLE) && !reset) || (r_state == S_DONE);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_n;
   end

   // Next-state and control decode.
   always_comb begin
      w_state_n = r_state;
      w_load    = 1'b0;
      w_step    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (Start) begin
               w_load    = 1'b1;
               w_state_n = (w_div_zero || w_early) ? S_DONE : S_DIVIDING;
            end
         end
         S_DIVIDING: begin
            w_step = 1'b1;
            if (r_count == CNT_W'(1)) w_state_n = S_DONE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // Datapath and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rem     <= '0;
         r_shift   <= '0;
         r_dsr     <= '0;
         r_count   <= '0;
         quotient  <= '0;
         remainder <= '0;
         Error     <= 1'b0;
      end else if (w_load) begin
         if (w_div_zero) begin
            quotient  <= '1;
            remainder <= dividend;
            Error     <= 1'b1;
         end else if (w_early) begin
            quotient  <= '0;
            remainder <= dividend;
            Error     <= 1'b0;
         end else begin
            r_rem     <= '0;
            r_shift   <= dividend;
            r_dsr     <= divisor;
            r_count   <= CNT_W'(L_word);
            quotient  <= '0;
            remainder <= '0;
            Error     <= 1'b0;
         end
      end else if (w_step) begin
         r_rem   <= w_rem_n;
         r_shift <= w_shift_n;
         r_count <= r_count - CNT_W'(1);
         // Last step: publish the result produced on this same edge.
         if (r_count == CNT_W'(1)) begin
            quotient  <= w_shift_n;
            remainder <= w_rem_n;
         end
      end
   end

endmodule

// File: tb/tb_divider_asm_0.sv
// Self-checking bench for divider_asm_0 (L_word=4): directed vector table,
// exhaustive and random operations against an arithmetic reference model,
// and hand-written handshake/reset sequences.
module tb_divider_asm_0;

   localparam int unsigned L = 4;
`ifdef DIVIDER_EARLY_EXIT_EN
   localparam int EE_LAT = 0;
`else
   localparam int EE_LAT = L;
`endif

   logic         clock = 1'b0;
   logic         reset;
   logic [L-1:0] dividend;
   logic [L-1:0] divisor;
   logic         Start;
   logic [L-1:0] quotient;
   logic [L-1:0] remainder;
   logic         Ready;
   logic         Error;

   int n_pass  = 0;
   int n_total = 0;

   divider_asm_0 #(.L_word(L)) dut (
      .clock     (clock),
      .reset     (reset),
      .dividend  (dividend),
      .divisor   (divisor),
      .Start     (Start),
      .quotient  (quotient),
      .remainder (remainder),
      .Ready     (Ready),
      .Error     (Error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [L-1:0] a;
      logic [L-1:0] b;
      logic [L-1:0] q;
      logic [L-1:0] r;
      logic         e;
      int           lat;
   } vec_t;

   vec_t tbl[9];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp)
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else
         n_pass++;
   endtask

   // Reference: plain arithmetic. Latency counts edges after the load edge.
   task automatic model(input int a, input int b,
                        output int q, output int r, output int e, output int lat);
      if (b == 0) begin
         q = (1 << L) - 1; r = a; e = 1; lat = 0;
      end else begin
         q = a / b; r = a % b; e = 0;
         lat = (a < b) ? EE_LAT : L;
      end
   endtask

   // Issue one operation from a Ready state and wait for completion.
   task automatic run_op(input int a, input int b,
                         output int q, output int r, output int e, output int lat);
      dividend = L'(a);
      divisor  = L'(b);
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
      dividend = L'($urandom);
      divisor  = L'($urandom);
      lat = 0;
      while (!Ready && lat < 20) begin
         tick();
         lat++;
      end
      q = int'(quotient);
      r = int'(remainder);
      e = int'(Error);
   endtask

   task automatic check_op(input string tag, input int a, input int b);
      int q, r, e, lat, mq, mr, me, mlat;
      model(a, b, mq, mr, me, mlat);
      run_op(a, b, q, r, e, lat);
      if (q != mq || r != mr || e != me || lat != mlat)
         $display("FAIL %s %0d/%0d: got q=%0d r=%0d e=%0d lat=%0d expected q=%0d r=%0d e=%0d lat=%0d",
                  tag, a, b, q, r, e, lat, mq, mr, me, mlat);
      else
         n_pass++;
      n_total++;
   endtask

   initial begin
      int q, r, e, lat;

      tbl[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, L};
      tbl[1] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1, 0};
      tbl[2] = '{4'd9,  4'd3,  4'd3,  4'd0, 1'b0, L};
      tbl[3] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, L};
      tbl[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, EE_LAT};
      tbl[5] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, L};
      tbl[6] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, EE_LAT};
      tbl[7] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 0};
      tbl[8] = '{4'd14, 4'd5,  4'd2,  4'd4, 1'b0, L};

      reset = 1'b1; Start = 1'b0; dividend = '0; divisor = '0;
      tick();
      chk("reset_ready", int'(Ready), 0);
      tick();
      chk("reset_q", int'(quotient), 0);
      chk("reset_r", int'(remainder), 0);
      chk("reset_err", int'(Error), 0);
      reset = 1'b0;
      #1;
      chk("idle_ready", int'(Ready), 1);

      // Directed vector table.
      for (int i = 0; i < 9; i++) begin
         run_op(int'(tbl[i].a), int'(tbl[i].b), q, r, e, lat);
         chk($sformatf("tbl%0d_q", i), q, int'(tbl[i].q));
         chk($sformatf("tbl%0d_r", i), r, int'(tbl[i].r));
         chk($sformatf("tbl%0d_err", i), e, int'(tbl[i].e));
         chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      end

      // Exhaustive, back-to-back from S_done.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            check_op("exh", a, b);

      // Random.
      for (int i = 0; i < 100; i++)
         check_op("rnd", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

      // Busy-ignore: second Start during S_dividing is dropped.
      dividend = 4'd15; divisor = 4'd2; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      dividend = 4'd6; divisor = 4'd3; Start = 1'b1;
      tick();
      Start = 1'b0;
      lat = 2;
      while (!Ready && lat < 20) begin
         tick();
         lat++;
      end
      chk("busy_lat", lat, L);
      chk("busy_q", int'(quotient), 7);
      chk("busy_r", int'(remainder), 1);
      tick();
      chk("busy_hold_ready", int'(Ready), 1);
      chk("busy_hold_q", int'(quotient), 7);

      // Reset from S_done clears a divide-by-zero result.
      run_op(7, 0, q, r, e, lat);
      chk("dz_err", e, 1);
      reset = 1'b1;
      tick();
      chk("rst_done_q", int'(quotient), 0);
      chk("rst_done_r", int'(remainder), 0);
      chk("rst_done_err", int'(Error), 0);
      chk("rst_done_ready", int'(Ready), 0);
      reset = 1'b0;
      #1;

      // Reset mid-operation abandons the division.
      dividend = 4'd14; divisor = 4'd5; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("rst_mid_ready_busy", int'(Ready), 0);
      tick();
      chk("rst_mid_ready", int'(Ready), 0);
      chk("rst_mid_q", int'(quotient), 0);
      chk("rst_mid_r", int'(remainder), 0);
      chk("rst_mid_err", int'(Error), 0);
      reset = 1'b0;
      #1;
      chk("rst_mid_ready_after", int'(Ready), 1);
      for (int i = 0; i < 6; i++) tick();
      chk("rst_mid_no_finish_q", int'(quotient), 0);
      chk("rst_mid_no_finish_r", int'(remainder), 0);
      chk("rst_mid_idle_ready", int'(Ready), 1);

      // Held Start: result visible one cycle in S_done, then reload.
      dividend = 4'd10; divisor = 4'd3; Start = 1'b1;
      tick();
      lat = 0;
      while (!Ready && lat < 20) begin
         tick();
         lat++;
      end
      chk("held_lat1", lat, L);
      chk("held_q1", int'(quotient), 3);
      chk("held_r1", int'(remainder), 1);
      tick();
      chk("held_reload_ready", int'(Ready), 0);
      lat = 0;
      while (!Ready && lat < 20) begin
         tick();
         lat++;
      end
      chk("held_lat2", lat, L);
      chk("held_q2", int'(quotient), 3);
      chk("held_r2", int'(remainder), 1);
      Start = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/divider_asm_0.md
Name: divider_asm_0

Overview:
Sequential restoring divider (shift-subtract). It is the inverse counterpart of the shift-add ASM multiplier in the Chapter 10 arithmetic set, and uses the same Start/Ready handshake so the two blocks are interchangeable in benches and datapaths. The block computes an unsigned quotient and remainder in a fixed L_word cycles, and flags divide-by-zero.

Parameters:
L_word, 4, width of dividend, divisor, quotient and remainder (must be >= 2)

Ports:
clock  input  1  single system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock
dividend  input  L_word  unsigned dividend; sampled on the load edge only
divisor  input  L_word  unsigned divisor; sampled on the load edge only
Start  input  1  request to begin a division; honoured only while Ready=1
quotient  output  L_word  registered quotient; valid while state==S_done
remainder  output  L_word  registered remainder; valid while state==S_done
Ready  output  1  block can accept Start; = (state==S_idle && !reset) || state==S_done
Error  output  1  registered flag; 1 in S_done when the last accepted divisor was 0

Behaviour:
- States (2-bit): S_idle=0, S_dividing=1, S_done=2. Any other encoding goes to S_idle at the next edge.
- Reset: on the rising edge of clock with reset=1, the block sets:
  - state=S_idle
  - quotient=0, remainder=0, Error=0
  - internal rem register=0, shift register=0, count=0
- Ready is combinationally 0 while reset=1. Reset takes priority over every other event, including in mid-operation, where the operation is abandoned.
- Load edge (Ready=1 and Start=1, in state S_idle or S_done):
  - If divisor!=0:
    - rem register (L_word+1 bits) <= 0
    - shift register <= dividend
    - divisor register <= divisor
    - count <= L_word
    - quotient <= 0, remainder <= 0, Error <= 0
    - state <= S_dividing
  - If divisor==0:
    - quotient <= all ones, remainder <= dividend, Error <= 1
    - state <= S_done (one-edge completion)
- S_dividing, each edge performs one step:
  - trial = {rem[L_word-1:0], shift[L_word-1]} - {1'b0, divisor_reg}, computed L_word+1 bits wide.
  - If trial is non-negative (MSB 0): rem <= trial; shift <= {shift[L_word-2:0], 1}.
  - Otherwise: rem <= {rem[L_word-1:0], shift[L_word-1]}; shift <= {shift[L_word-2:0], 0}.
  - count <= count-1.
  - On the edge where count==1, the step result is also written: quotient <= new shift, remainder <= new rem[L_word-1:0], state <= S_done.
- Latency: for divisor!=0, S_done and Ready=1 are reached exactly L_word edges after the load edge.
- Start while in S_dividing is ignored; the dividend and divisor inputs may change freely after the load edge.
- S_done: the block holds quotient, remainder and Error. Start=1 triggers a load edge (back-to-back operation, no idle cycle required). Start=0 keeps the block in S_done.
- S_idle: Start=0 keeps the block in S_idle.
- Start held high across completion: a new load occurs on the first edge in which the state is S_done.
- Invariant for divisor!=0: dividend == quotient*divisor + remainder, and remainder < divisor.

Optional Feature:
Macro DIVIDER_EARLY_EXIT_EN.
- Defined: on a load edge with divisor!=0 and dividend < divisor, the block sets quotient <= 0, remainder <= dividend, Error <= 0 and state <= S_done, so it completes in one edge.
- Undefined: this case takes the normal L_word-cycle path, with identical final quotient and remainder values.

Test Plan:
- Basic: L_word=4; reset 2 edges; dividend=13, divisor=4, Start for 1 cycle -> Ready=0 for 4 edges, then S_done with quotient=3, remainder=1, Error=0.
- Divide-by-zero: dividend=7, divisor=0 -> S_done on the next edge with quotient=15, remainder=7, Error=1. A following 9/3 -> quotient=3, remainder=0, Error=0.
- Exhaustive: all dividend/divisor pairs in 0..15 from S_done back-to-back -> quotient and remainder match / and %; divisor 0 rows match the Error rule. Check the latency count: L_word edges normally; with DIVIDER_EARLY_EXIT_EN, 1 edge when dividend<divisor.
- Busy-ignore: start 15/2; pulse Start with 6/3 at the second edge of S_dividing -> result quotient=7, remainder=1; the second request is dropped.
- Reset mid-operation: start 14/5; assert reset at the second edge of S_dividing -> next edge state=S_idle, quotient=0, remainder=0, Error=0; Ready=0 while reset is high, then 1.
- Held Start: keep Start=1 with 10/3 -> results quotient=3, remainder=1 are visible for exactly one cycle in S_done, then the block reloads and repeats.
